// File: rtl/spike_frame_feeder_pkg.sv
// Shared definitions for the spike frame feeder: FSM state encoding,
// configuration strobe length and default widths matching the LIF neuron top.
package spike_frame_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CFG   = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } feeder_state_t;

    localparam int unsigned CFG_LOAD_CYCLES = 2;
    localparam int unsigned S_WIDTH_DEFAULT = 8;
    localparam int unsigned V_WIDTH_DEFAULT = 12;

endpackage

// File: rtl/spike_frame_fifo.sv
// Small power-of-two frame buffer with wrapping pointers and an occupancy count.
module spike_frame_fifo #(
    parameter int unsigned S_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PTR_WIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [S_WIDTH-1:0]   din,
    output logic [S_WIDTH-1:0]   head,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   count
);

    logic [S_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count == (PTR_WIDTH+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_frame_feeder.sv
// Feeds buffered spike frames to a LIF neuron: loads Vth/Vrest, issues one start
// per frame, waits (with watchdog) for neuron valid and returns the spike result.
module spike_frame_feeder
    import spike_frame_feeder_pkg::*;
#(
    parameter int unsigned S_WIDTH       = S_WIDTH_DEFAULT,
    parameter int unsigned V_WIDTH       = V_WIDTH_DEFAULT,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned PTR_WIDTH     = 2,
    parameter int unsigned TIMEOUT_WIDTH = 6,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [V_WIDTH-1:0]   cfg_vth,
    input  logic [V_WIDTH-1:0]   cfg_vrest,
    output logic                 cfg_ready,
    input  logic                 frame_valid,
    input  logic [S_WIDTH-1:0]   frame_data,
    output logic                 frame_ready,
    output logic                 start,
    output logic [S_WIDTH-1:0]   input_spike,
    output logic                 v_th_load,
    output logic                 v_rest_load,
    output logic [V_WIDTH-1:0]   Vth,
    output logic [V_WIDTH-1:0]   Vrest,
    input  logic                 nrn_valid,
    input  logic                 nrn_spike,
    output logic                 out_valid,
    output logic                 out_spike,
    output logic [CNT_WIDTH-1:0] spike_cnt,
    output logic                 busy,
    output logic                 timeout_err
);

    // The edge that would carry the watchdog to all-ones is the timeout edge.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    feeder_state_t           state;
    logic [1:0]              load_cnt;
    logic [TIMEOUT_WIDTH-1:0] wd;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [S_WIDTH-1:0]      fifo_head;
    logic [PTR_WIDTH:0]      fifo_count;
    logic [PTR_WIDTH:0]      count_next;
    logic                    idle_busy;

    assign frame_ready = rst && !fifo_full;
    assign cfg_ready   = rst && (state == IDLE);
    assign push        = frame_valid && frame_ready;
    assign pop         = (state == IDLE) && !cfg_valid && !fifo_empty;

    spike_frame_fifo #(
        .S_WIDTH   (S_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (frame_data),
        .head (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    // busy is registered, so it is computed from the post-edge FIFO occupancy.
    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fifo_count - 1'b1;
        end
        idle_busy = (count_next != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            load_cnt    <= '0;
            wd          <= '0;
            start       <= 1'b0;
            input_spike <= '0;
            v_th_load   <= 1'b0;
            v_rest_load <= 1'b0;
            Vth         <= '0;
            Vrest       <= '0;
            out_valid   <= 1'b0;
            out_spike   <= 1'b0;
            spike_cnt   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            start     <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        state       <= CFG;
                        Vth         <= cfg_vth;
                        Vrest       <= cfg_vrest;
                        v_th_load   <= 1'b1;
                        v_rest_load <= 1'b1;
                        load_cnt    <= 2'd1;
                        busy        <= 1'b1;
                    end else if (!fifo_empty) begin
                        state       <= ISSUE;
                        input_spike <= fifo_head;
                        start       <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        busy <= idle_busy;
                    end
                end
                CFG: begin
                    if (load_cnt == 2'(CFG_LOAD_CYCLES)) begin
                        v_th_load   <= 1'b0;
                        v_rest_load <= 1'b0;
                        state       <= IDLE;
                        busy        <= idle_busy;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    wd    <= '0;
                end
                WAIT: begin
                    if (nrn_valid) begin
                        out_valid <= 1'b1;
                        out_spike <= nrn_spike;
                        if (nrn_spike && (spike_cnt != '1)) begin
                            spike_cnt <= spike_cnt + 1'b1;
                        end
                        state <= IDLE;
                        busy  <= idle_busy;
                    end else if (wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        busy        <= idle_busy;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_frame_feeder.sv
// Self-checking bench for spike_frame_feeder with a behavioural neuron and scoreboards.
module tb_spike_frame_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [11:0] cfg_vth = '0;
    logic [11:0] cfg_vrest = '0;
    logic        cfg_ready;
    logic        frame_valid = 1'b0;
    logic [7:0]  frame_data = '0;
    logic        frame_ready;
    logic        start;
    logic [7:0]  input_spike;
    logic        v_th_load;
    logic        v_rest_load;
    logic [11:0] Vth;
    logic [11:0] Vrest;
    logic        nrn_valid = 1'b0;
    logic        nrn_spike = 1'b0;
    logic        out_valid;
    logic        out_spike;
    logic [15:0] spike_cnt;
    logic        busy;
    logic        timeout_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic [7:0] start_q[$];
    int         start_t_q[$];
    logic       ov_q[$];
    logic       resp_q[$];

    bit   nrn_en = 1'b0;
    bit   nrn_rand = 1'b0;
    int   nrn_lat = 4;
    logic nrn_resp = 1'b0;

    always #5 clk = ~clk;

    spike_frame_feeder #(
        .S_WIDTH(8), .V_WIDTH(12), .FIFO_DEPTH(4), .PTR_WIDTH(2),
        .TIMEOUT_WIDTH(6), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_vth(cfg_vth), .cfg_vrest(cfg_vrest), .cfg_ready(cfg_ready),
        .frame_valid(frame_valid), .frame_data(frame_data), .frame_ready(frame_ready),
        .start(start), .input_spike(input_spike),
        .v_th_load(v_th_load), .v_rest_load(v_rest_load), .Vth(Vth), .Vrest(Vrest),
        .nrn_valid(nrn_valid), .nrn_spike(nrn_spike),
        .out_valid(out_valid), .out_spike(out_spike), .spike_cnt(spike_cnt),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Monitor: records every start (with frame and cycle) and every result.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (start) begin
                start_q.push_back(input_spike);
                start_t_q.push_back(cyc);
            end
            if (out_valid) ov_q.push_back(out_spike);
        end
    end

    // Neuron model: answers each start after a latency with a chosen spike bit.
    initial begin
        int   lat;
        logic sp;
        forever begin
            @(posedge clk);
            #1;
            if (start && nrn_en) begin
                lat = nrn_rand ? int'($urandom_range(10, 1)) : nrn_lat;
                sp  = nrn_rand ? logic'($urandom_range(1, 0)) : nrn_resp;
                repeat (lat) @(posedge clk);
                #1;
                nrn_valid = 1'b1;
                nrn_spike = sp;
                resp_q.push_back(sp);
                @(posedge clk);
                #1;
                nrn_valid = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_q();
        start_q.delete();
        start_t_q.delete();
        ov_q.delete();
        resp_q.delete();
    endtask

    task automatic push_frame(input logic [7:0] d);
        int w = 0;
        frame_valid = 1'b1;
        frame_data  = d;
        #1;
        while (!frame_ready && w < 300) begin
            tick(1);
            w++;
        end
        total_cnt++;
        if (!frame_ready) $display("FAIL push_accept: frame_ready got %b required 1 within 300 cycles", frame_ready);
        else pass_cnt++;
        tick(1);
        frame_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int w = 0;
        while (ov_q.size() < n && w < budget) begin
            tick(1);
            w++;
        end
        total_cnt++;
        if (ov_q.size() < n) $display("FAIL result_wait: got %0d results required %0d", ov_q.size(), n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        total_cnt++; if (start !== 1'b0 || out_valid !== 1'b0 || v_th_load !== 1'b0) $display("FAIL reset_strobes: got %b%b%b required 000", start, out_valid, v_th_load); else pass_cnt++;
        total_cnt++; if (Vth !== 12'h000 || Vrest !== 12'h000) $display("FAIL reset_vth_vrest: got %h/%h required 000/000", Vth, Vrest); else pass_cnt++;
        total_cnt++; if (spike_cnt !== 16'h0 || timeout_err !== 1'b0 || busy !== 1'b0) $display("FAIL reset_status: got cnt=%h err=%b busy=%b required 0", spike_cnt, timeout_err, busy); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (frame_ready !== 1'b1) $display("FAIL reset_frame_ready: got %b required 1", frame_ready); else pass_cnt++;
        tick(1);
        total_cnt++; if (cfg_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_idle: got cfg_ready=%b busy=%b required 1/0", cfg_ready, busy); else pass_cnt++;
    endtask

    task automatic test_cfg();
        int lc = 1;
        cfg_vth   = 12'd256;
        cfg_vrest = 12'hFE6;
        cfg_valid = 1'b1;
        #1;
        total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_idle: got %b required 1", cfg_ready); else pass_cnt++;
        tick(1);
        cfg_valid = 1'b0;
        total_cnt++; if (v_th_load !== 1'b1 || v_rest_load !== 1'b1) $display("FAIL cfg_load_first: got %b%b required 11", v_th_load, v_rest_load); else pass_cnt++;
        total_cnt++; if (Vth !== 12'h100 || Vrest !== 12'hFE6) $display("FAIL cfg_values: got %h/%h required 100/fe6", Vth, Vrest); else pass_cnt++;
        total_cnt++; if (cfg_ready !== 1'b0) $display("FAIL cfg_ready_busy: got %b required 0", cfg_ready); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (v_th_load && v_rest_load) lc++;
        end
        total_cnt++; if (lc !== 2) $display("FAIL cfg_load_cycles: got %0d required 2", lc); else pass_cnt++;
        total_cnt++; if (cfg_ready !== 1'b1 || Vth !== 12'h100) $display("FAIL cfg_hold: got ready=%b Vth=%h required 1/100", cfg_ready, Vth); else pass_cnt++;
    endtask

    task automatic test_single_frame();
        int k = 0;
        clear_q();
        nrn_en = 1'b1; nrn_rand = 1'b0; nrn_lat = 8; nrn_resp = 1'b1;
        push_frame(8'hFB);
        total_cnt++; if (start !== 1'b0 || busy !== 1'b1) $display("FAIL single_push_edge: got start=%b busy=%b required 0/1", start, busy); else pass_cnt++;
        tick(1);
        total_cnt++; if (start !== 1'b1 || input_spike !== 8'hFB) $display("FAIL single_start: got start=%b spike=%h required 1/fb", start, input_spike); else pass_cnt++;
        while (!out_valid && k < 100) begin
            tick(1);
            k++;
        end
        total_cnt++; if (k !== 9) $display("FAIL single_latency: got %0d cycles start-to-out_valid required 9", k); else pass_cnt++;
        total_cnt++; if (out_spike !== 1'b1 || spike_cnt !== 16'd1) $display("FAIL single_result: got spike=%b cnt=%0d required 1/1", out_spike, spike_cnt); else pass_cnt++;
        tick(3);
        total_cnt++; if (ov_q.size() !== 1 || start_q.size() !== 1) $display("FAIL single_pulses: got %0d results %0d starts required 1/1", ov_q.size(), start_q.size()); else pass_cnt++;
    endtask

    task automatic test_burst();
        logic [7:0] frames [5];
        int occ = 0;
        frames[0] = 8'h1A; frames[1] = 8'h11; frames[2] = 8'h02; frames[3] = 8'h57; frames[4] = 8'h3D;
        clear_q();
        nrn_en = 1'b1; nrn_rand = 1'b0; nrn_lat = 3; nrn_resp = 1'b0;
        // Holding cfg_valid keeps the sequencer away from the FIFO so frames pile up.
        cfg_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame_valid = 1'b1;
            frame_data  = frames[i];
            #1;
            total_cnt++; if (frame_ready !== (occ < 4)) $display("FAIL burst_ready_%0d: got %b required %b", i, frame_ready, occ < 4); else pass_cnt++;
            tick(1);
            occ++;
        end
        frame_data = frames[4];
        #1;
        total_cnt++; if (frame_ready !== 1'b0) $display("FAIL burst_full: got %b required 0", frame_ready); else pass_cnt++;
        tick(1);
        total_cnt++; if (frame_ready !== 1'b0 || start_q.size() !== 0) $display("FAIL burst_held: got ready=%b starts=%0d required 0/0", frame_ready, start_q.size()); else pass_cnt++;
        cfg_valid = 1'b0;
        push_frame(frames[4]);
        wait_results(5, 400);
        tick(2);
        total_cnt++; if (start_q.size() !== 5) $display("FAIL burst_count: got %0d starts required 5", start_q.size()); else pass_cnt++;
        for (int i = 0; i < 5 && i < start_q.size(); i++) begin
            total_cnt++; if (start_q[i] !== frames[i]) $display("FAIL burst_order_%0d: got %h required %h", i, start_q[i], frames[i]); else pass_cnt++;
        end
        total_cnt++; if (spike_cnt !== 16'd1) $display("FAIL burst_cnt: got %0d required 1", spike_cnt); else pass_cnt++;
    endtask

    task automatic test_cfg_priority();
        clear_q();
        nrn_en = 1'b1; nrn_rand = 1'b0; nrn_lat = 3; nrn_resp = 1'b1;
        push_frame(8'h77);
        cfg_vth = 12'h0AB; cfg_vrest = 12'hF00; cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
        total_cnt++; if (v_th_load !== 1'b1 || start !== 1'b0 || Vth !== 12'h0AB) $display("FAIL prio_cfg_first: got load=%b start=%b Vth=%h required 1/0/0ab", v_th_load, start, Vth); else pass_cnt++;
        tick(2);
        total_cnt++; if (start !== 1'b0 || v_th_load !== 1'b0 || start_q.size() !== 0) $display("FAIL prio_gap: got start=%b load=%b starts=%0d required 0/0/0", start, v_th_load, start_q.size()); else pass_cnt++;
        tick(1);
        total_cnt++; if (start !== 1'b1 || input_spike !== 8'h77) $display("FAIL prio_start: got start=%b spike=%h required 1/77", start, input_spike); else pass_cnt++;
        wait_results(1, 100);
        total_cnt++; if (spike_cnt !== 16'd2) $display("FAIL prio_cnt: got %0d required 2", spike_cnt); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int w = 0;
        clear_q();
        nrn_en = 1'b0;
        push_frame(8'hA5);
        while (!start && w < 10) begin
            tick(1);
            w++;
        end
        total_cnt++; if (start !== 1'b1) $display("FAIL to_start: got %b required 1", start); else pass_cnt++;
        for (int k = 1; k <= 64; k++) begin
            tick(1);
            if (k == 63) begin
                total_cnt++; if (timeout_err !== 1'b0 || cfg_ready !== 1'b0) $display("FAIL to_early: got err=%b ready=%b required 0/0", timeout_err, cfg_ready); else pass_cnt++;
            end
            if (k == 64) begin
                total_cnt++; if (timeout_err !== 1'b1 || cfg_ready !== 1'b1) $display("FAIL to_fire: got err=%b ready=%b required 1/1", timeout_err, cfg_ready); else pass_cnt++;
            end
        end
        tick(2);
        total_cnt++; if (ov_q.size() !== 0) $display("FAIL to_no_result: got %0d results required 0", ov_q.size()); else pass_cnt++;
        nrn_en = 1'b1; nrn_lat = 4; nrn_resp = 1'b0;
        push_frame(8'h3C);
        wait_results(1, 100);
        tick(2);
        total_cnt++; if (start_q.size() !== 2 || start_q[start_q.size()-1] !== 8'h3C) $display("FAIL to_next_frame: got %0d starts last=%h required 2/3c", start_q.size(), start_q[start_q.size()-1]); else pass_cnt++;
        total_cnt++; if (timeout_err !== 1'b1 || spike_cnt !== 16'd2) $display("FAIL to_sticky: got err=%b cnt=%0d required 1/2", timeout_err, spike_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        clear_q();
        nrn_en = 1'b1; nrn_rand = 1'b0; nrn_lat = 30; nrn_resp = 1'b1;
        push_frame(8'h5A);
        tick(4);
        push_frame(8'hC3);
        tick(2);
        rst = 1'b0;
        #1;
        total_cnt++; if (start !== 1'b0 || out_valid !== 1'b0 || input_spike !== 8'h00 || v_th_load !== 1'b0) $display("FAIL rmid_strobes: got start=%b ov=%b spike=%h load=%b required 0", start, out_valid, input_spike, v_th_load); else pass_cnt++;
        total_cnt++; if (Vth !== 12'h0 || Vrest !== 12'h0 || spike_cnt !== 16'h0 || timeout_err !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_regs: got Vth=%h Vrest=%h cnt=%h err=%b busy=%b required 0", Vth, Vrest, spike_cnt, timeout_err, busy); else pass_cnt++;
        total_cnt++; if (frame_ready !== 1'b0 || cfg_ready !== 1'b0) $display("FAIL rmid_ready: got frame=%b cfg=%b required 0/0", frame_ready, cfg_ready); else pass_cnt++;
        tick(2);
        rst = 1'b1;
        #1;
        total_cnt++; if (frame_ready !== 1'b1) $display("FAIL rmid_release: got %b required 1", frame_ready); else pass_cnt++;
        tick(40);
        total_cnt++; if (ov_q.size() !== 0 || start_q.size() !== 1 || busy !== 1'b0) $display("FAIL rmid_aborted: got results=%0d starts=%0d busy=%b required 0/1/0", ov_q.size(), start_q.size(), busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        int ones = 0;
        clear_q();
        nrn_en = 1'b1; nrn_rand = 1'b1;
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            push_frame(d);
            exp_q.push_back(d);
            tick(int'($urandom_range(2, 0)));
        end
        wait_results(24, 2000);
        tick(2);
        total_cnt++; if (start_q.size() !== 24 || ov_q.size() !== 24) $display("FAIL b2b_counts: got %0d starts %0d results required 24/24", start_q.size(), ov_q.size()); else pass_cnt++;
        for (int i = 0; i < 24 && i < start_q.size() && i < ov_q.size() && i < resp_q.size(); i++) begin
            total_cnt++; if (start_q[i] !== exp_q[i] || ov_q[i] !== resp_q[i]) $display("FAIL b2b_item_%0d: got %h/%b required %h/%b", i, start_q[i], ov_q[i], exp_q[i], resp_q[i]); else pass_cnt++;
            if (resp_q[i]) ones++;
        end
        for (int i = 1; i < start_t_q.size(); i++) begin
            total_cnt++; if (start_t_q[i] - start_t_q[i-1] < 3) $display("FAIL b2b_gap_%0d: got %0d cycles required >=3", i, start_t_q[i] - start_t_q[i-1]); else pass_cnt++;
        end
        total_cnt++; if (spike_cnt !== 16'(ones)) $display("FAIL b2b_spike_cnt: got %0d required %0d", spike_cnt, ones); else pass_cnt++;
        nrn_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_single_frame();
        test_burst();
        test_cfg_priority();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spike_frame_feeder.md
Name: spike_frame_feeder

Overview:
- Upstream stage of the LIF neuron top (the neuron has ports start, input_spike, v_th_load, v_rest_load, Vth, Vrest, spike_out and valid).
- Accepts threshold/rest configuration and spike frames from a producer via valid/ready handshakes, and buffers frames in a small FIFO.
- Sequences the neuron: loads Vth/Vrest, issues one start pulse per frame, waits for neuron valid.
- Returns each frame's spike result and keeps a saturating output-spike count.

Parameters:
- S_WIDTH, 8, spike frame width; equals neuron input_spike width.
- V_WIDTH, 12, signed membrane-voltage width for Vth/Vrest.
- FIFO_DEPTH, 4, frame buffer entries; power of two, at least 2.
- PTR_WIDTH, 2, log2(FIFO_DEPTH).
- TIMEOUT_WIDTH, 6, width of the wait-for-valid watchdog counter.
- CNT_WIDTH, 16, width of the output-spike counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_vth  in  V_WIDTH  signed threshold.
- cfg_vrest  in  V_WIDTH  signed rest potential.
- cfg_ready  out  1  configuration accepted this cycle when high together with cfg_valid.
- frame_valid  in  1  producer frame valid.
- frame_data  in  S_WIDTH  spike frame.
- frame_ready  out  1  FIFO can accept a frame.
- start  out  1  one-cycle start pulse to the neuron.
- input_spike  out  S_WIDTH  frame presented to the neuron.
- v_th_load  out  1  neuron threshold load strobe.
- v_rest_load  out  1  neuron rest load strobe.
- Vth  out  V_WIDTH  threshold value to the neuron.
- Vrest  out  V_WIDTH  rest value to the neuron.
- nrn_valid  in  1  neuron valid.
- nrn_spike  in  1  neuron spike_out.
- out_valid  out  1  one-cycle result strobe.
- out_spike  out  1  result spike for the frame.
- spike_cnt  out  CNT_WIDTH  saturating count of out_spike=1 results.
- busy  out  1  FSM is not in IDLE, or the FIFO is non-empty.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE and the FIFO empties.
  - All outputs are 0, including Vth, Vrest, input_spike, spike_cnt and timeout_err.
  - frame_ready is 1 once rst is deasserted, because the FIFO is empty.
  - Reset mid-operation aborts any frame in progress; no out_valid follows.
- All outputs are registered, except frame_ready (= !full) and cfg_ready (= state==IDLE).
- FIFO:
  - A push occurs on frame_valid && frame_ready.
  - A pop occurs on the ISSUE entry edge.
  - Pointers wrap modulo FIFO_DEPTH; a count register tracks occupancy.
  - When full, frame_ready is 0 and frame_data is ignored.
  - A push and a pop on the same edge leave the count unchanged.
- FSM states: IDLE, CFG, ISSUE, WAIT.
- IDLE:
  - If cfg_valid, go to CFG and latch cfg_vth/cfg_vrest into Vth/Vrest. Configuration has priority over frames.
  - Otherwise, if the FIFO is non-empty, go to ISSUE: pop the head into input_spike and assert start.
- CFG:
  - v_th_load and v_rest_load are high for exactly 2 cycles.
  - Then return to IDLE.
  - Vth/Vrest hold their values until the next configuration.
- ISSUE:
  - start is high for exactly 1 cycle.
  - Next state is WAIT; the watchdog clears to 0.
- WAIT:
  - input_spike is held stable.
  - On nrn_valid: capture nrn_spike into out_spike, pulse out_valid for 1 cycle, increment spike_cnt if nrn_spike=1 (saturating at all-ones), and go to IDLE.
  - If the watchdog reaches 2^TIMEOUT_WIDTH-1 before nrn_valid: set timeout_err, go to IDLE, and emit no out_valid.
  - nrn_valid on the same edge as the watchdog reaching its limit counts as valid.
- nrn_valid outside WAIT is ignored.
- timeout_err clears only on reset.
- Latency:
  - A frame pushed into an empty FIFO while IDLE makes start go high one cycle after the push edge.
  - out_valid rises one cycle after nrn_valid is sampled.
  - Back-to-back frames are separated by at least one IDLE cycle.

Decomposition:
- Shared package holds:
  - the FSM state encoding (2-bit localparams IDLE, CFG, ISSUE, WAIT);
  - the configuration-strobe length constant CFG_LOAD_CYCLES=2;
  - the default S_WIDTH/V_WIDTH values, matching the neuron top.
- One natural sub-module: spike_frame_fifo (parameterised S_WIDTH, FIFO_DEPTH, PTR_WIDTH), with push/pop/full/empty/head.

Test Plan:
- Reset then configure: drive cfg_valid with Vth=256 and Vrest=-26 (12'hFE6).
  - Required: v_th_load and v_rest_load high for 2 cycles, Vth=12'h100, Vrest=12'hFE6.
  - Required: cfg_ready low during CFG.
- Single frame 8'b11111011 with neuron model returning valid after 8 cycles and spike=1.
  - Required: start pulses once with input_spike=8'hFB.
  - Required: out_valid with out_spike=1, spike_cnt=1.
- Burst of 5 frames (8'h1A, 8'h11, 8'h02, 8'h57, 8'h3D) with the FIFO at depth 4 and the neuron stalled.
  - Required: frame_ready drops after 4 frames held in the FIFO; the 5th is accepted after the first pop.
  - Required: starts issue in order 1A, 11, 02, 57, 3D.
- Neuron never asserts valid.
  - Required: timeout_err=1 after 63 WAIT cycles, no out_valid, FSM back in IDLE, next frame still issued.
- cfg_valid and a non-empty FIFO in the same IDLE cycle.
  - Required: CFG runs first; start follows after CFG completes.
- Assert rst low during WAIT.
  - Required: all outputs immediately 0, FIFO empty, frame_ready=1 after release, no stray out_valid.
